// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined logic unit: opcode encodings, flag
// layout and the single-bit operation used by the op core.
package logic_unit_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND   = 3'b000;
  localparam op_t OP_OR    = 3'b001;
  localparam op_t OP_XOR   = 3'b010;
  localparam op_t OP_NAND  = 3'b011;
  localparam op_t OP_NOR   = 3'b100;
  localparam op_t OP_XNOR  = 3'b101;
  localparam op_t OP_NOTA  = 3'b110;
  localparam op_t OP_PASSB = 3'b111;

  // A buffer entry is {flags, data}: WIDTH + FLAG_W bits.
  localparam int FLAG_W = 3;

  typedef struct packed {
    logic zero;
    logic ones;
    logic parity;
  } flags_t;

  function automatic logic bit_op(input op_t op, input logic a, input logic b);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NAND:  r = ~(a & b);
      OP_NOR:   r = ~(a | b);
      OP_XNOR:  r = ~(a ^ b);
      OP_NOTA:  r = ~a;
      default:  r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand and result handshake bundle for logic_unit_pipe.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8
);
  import logic_unit_pkg::*;

  logic             in_valid;
  logic             in_ready;
  op_t              op;
  logic             acc;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             zero;
  logic             ones;
  logic             parity;

  modport master (
    output in_valid, op, acc, a, b, out_ready,
    input  in_ready, out_valid, f, zero, ones, parity
  );

  modport slave (
    input  in_valid, op, acc, a, b, out_ready,
    output in_ready, out_valid, f, zero, ones, parity
  );

endinterface

// File: rtl/logic_op_core.sv
// Combinational WIDTH-bit operation select plus zero/ones/parity reduction.
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] f,
  output flags_t           flags
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign f[gi] = bit_op(op, a[gi], b[gi]);
  end

  assign flags.zero   = ~|f;
  assign flags.ones   = &f;
  assign flags.parity = ^f;

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: one-cycle op stage feeding a 2-entry result
// FIFO, with an accumulator that can stand in for operand B.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  logic_unit_pipe_if.slave   bus
);

  localparam int ENTRY_W = WIDTH + FLAG_W;

  logic [ENTRY_W-1:0] entry_q [2];
  logic [ENTRY_W-1:0] entry_d [2];
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [1:0]         count_q, count_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic               ready_en_q, ready_en_d;

  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH-1:0]   res;
  flags_t             res_flags;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  assign b_eff = bus.acc ? acc_q : bus.b;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .op    (bus.op),
    .a     (bus.a),
    .b     (b_eff),
    .f     (res),
    .flags (res_flags)
  );

  // ready_en_q keeps the unit closed during reset and for the first edge after release.
  assign bus.in_ready  = ready_en_q & ((count_q != 2'd2) | bus.out_ready);
  assign bus.out_valid = (count_q != 2'd0);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  assign head       = bus.out_valid ? entry_q[rd_ptr_q] : '0;
  assign bus.f      = head[WIDTH-1:0];
  assign bus.zero   = head[WIDTH+2];
  assign bus.ones   = head[WIDTH+1];
  assign bus.parity = head[WIDTH];

  always_comb begin
    entry_d    = entry_q;
    acc_d      = acc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ready_en_d = 1'b1;

    // The accumulator tracks acceptance order so back-to-back ACC beats chain.
    if (push) begin
      entry_d[wr_ptr_q] = {res_flags, res};
      acc_d             = res;
      wr_ptr_d          = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q    <= '{default: '0};
      acc_q      <= '0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      entry_q    <= entry_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ready_en_q <= ready_en_d;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: directed vectors push expected results,
// a negedge monitor pops and compares each retired beat.
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_unit_pipe_if #(.WIDTH(W)) u_if ();

  logic_unit_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  typedef struct packed {
    logic [W-1:0] f;
    logic         zero;
    logic         ones;
    logic         parity;
  } exp_t;

  exp_t         exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] acc_m = '0;
  bit           rand_stall = 1'b0;

  function automatic exp_t mk(input logic [W-1:0] f);
    exp_t e;
    e.f      = f;
    e.zero   = (f == '0);
    e.ones   = (f == {W{1'b1}});
    e.parity = ^f;
    return e;
  endfunction

  function automatic logic [W-1:0] ref_op(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return b;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: retire beats against the scoreboard and check stall stability.
  initial begin : monitor
    logic hold;
    exp_t held;
    exp_t e;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold && u_if.out_valid)
          chk("stall stable", {u_if.f, u_if.zero, u_if.ones, u_if.parity}, held);
        hold = 1'b0;
        if (u_if.out_valid && !u_if.out_ready) begin
          hold = 1'b1;
          held = {u_if.f, u_if.zero, u_if.ones, u_if.parity};
        end
        if (u_if.out_valid && u_if.out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected beat: got f=%0h expected none", u_if.f);
          end else begin
            e = exp_q.pop_front();
            chk("result f", u_if.f, e.f);
            chk("result flags", {u_if.zero, u_if.ones, u_if.parity}, {e.zero, e.ones, e.parity});
          end
        end
      end
    end
  end

  initial begin : staller
    forever begin
      @(posedge clk);
      #1;
      if (rand_stall) u_if.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Present one beat; returns at posedge+1 of its accepting edge.
  task automatic send(input op_t op, input logic acc, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] ef);
    int t;
    bit done;
    t    = 0;
    done = 1'b0;
    u_if.in_valid = 1'b1;
    u_if.op  = op;
    u_if.acc = acc;
    u_if.a   = a;
    u_if.b   = b;
    while (!done) begin
      @(negedge clk);
      if (u_if.in_ready) begin
        @(posedge clk);
        exp_q.push_back(mk(ef));
        acc_m = ef;
        $display("push op=%0d acc=%0b a=%0h b=%0h expect f=%0h", op, acc, a, b, ef);
        done = 1'b1;
      end else if (++t > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept timeout: got in_ready=0 expected 1 within 200 cycles");
        done = 1'b1;
      end
    end
    #1;
    u_if.in_valid = 1'b0;
    u_if.op  = 3'b000;
    u_if.acc = 1'b0;
    u_if.a   = '0;
    u_if.b   = '0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain empty", exp_q.size(), 0);
    chk("idle out_valid", u_if.out_valid, 1'b0);
  endtask

  initial begin : stim
    logic [W-1:0] a, b, bb;
    op_t          op;
    logic         ac;

    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    u_if.op  = 3'b000;
    u_if.acc = 1'b0;
    u_if.a   = '0;
    u_if.b   = '0;

    #1;
    chk("reset in_ready", u_if.in_ready, 1'b0);
    chk("reset out_valid", u_if.out_valid, 1'b0);
    chk("reset f", {u_if.f, u_if.zero, u_if.ones, u_if.parity}, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("release in_ready", u_if.in_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("post-release in_ready", u_if.in_ready, 1'b1);

    // OR with latency-1 visibility
    send(OP_OR, 1'b0, 8'hFF, 8'h01, 8'hFF);
    chk("latency out_valid", u_if.out_valid, 1'b1);
    chk("latency f", u_if.f, 8'hFF);
    chk("latency ones/parity", {u_if.ones, u_if.parity}, 2'b10);
    send(OP_XOR, 1'b0, 8'h59, 8'hBE, 8'hE7);
    send(OP_NOR, 1'b0, 8'hAA, 8'h72, 8'h05);
    drain();

    // Back-pressure: third beat held until consumer releases
    u_if.out_ready = 1'b0;
    send(OP_AND, 1'b0, 8'h3C, 8'h0F, 8'h0C);
    send(OP_NAND, 1'b0, 8'hF0, 8'hFF, 8'h0F);
    @(negedge clk);
    chk("full in_ready", u_if.in_ready, 1'b0);
    @(posedge clk);
    #1;
    fork
      send(OP_XNOR, 1'b0, 8'hA5, 8'h5A, 8'h00);
      begin
        repeat (3) @(negedge clk);
        chk("held in_ready", u_if.in_ready, 1'b0);
        chk("held head f", u_if.f, 8'h0C);
        @(posedge clk);
        #1 u_if.out_ready = 1'b1;
      end
    join
    drain();

    // Accumulator chain; B is ignored on ACC beats
    send(OP_PASSB, 1'b0, 8'h00, 8'h0F, 8'h0F);
    send(OP_OR, 1'b1, 8'hF0, 8'h33, 8'hFF);
    send(OP_XOR, 1'b1, 8'hFF, 8'h00, 8'h00);
    send(OP_NOTA, 1'b1, 8'h96, 8'hFF, 8'h69);
    drain();

    // Reset with two buffered beats
    u_if.out_ready = 1'b0;
    send(OP_AND, 1'b0, 8'hFF, 8'hFF, 8'hFF);
    send(OP_OR, 1'b0, 8'h01, 8'h02, 8'h03);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-reset out_valid", u_if.out_valid, 1'b0);
    chk("mid-reset f", {u_if.f, u_if.zero, u_if.ones, u_if.parity}, '0);
    chk("mid-reset in_ready", u_if.in_ready, 1'b0);
    exp_q.delete();
    acc_m = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    u_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("re-release in_ready", u_if.in_ready, 1'b1);
    send(OP_PASSB, 1'b1, 8'hAA, 8'hFF, 8'h00);
    drain();

    // Random ops with random consumer stalls against the reference model
    rand_stall = 1'b1;
    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      ac = 1'($urandom_range(0, 1));
      a  = W'($urandom);
      b  = W'($urandom);
      bb = ac ? acc_m : b;
      send(op, ac, a, b, ref_op(op, a, bb));
    end
    rand_stall = 1'b0;
    @(posedge clk);
    #1 u_if.out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
